// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, NR+1 cycles per block, valid/ready on both sides.
// Optional AES_INV_ABORT_EN adds an abort input that kills the in-flight block and returns to IDLE.
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR4 = 4'(NR);

  typedef enum logic [1:0] {IDLE, ROUND, LAST, DONE} state_e;

  state_e       state_q, state_d;
  logic [3:0]   r_q, r_d;
  logic [127:0] data_q, data_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // Byte k of the state (k = 4*col + row) lives at [127-8k -: 8].
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] st);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127-8*(4*c+r) -: 8] = inv_sbox(st[127-8*src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = st[127-32*c -: 8];
      a1 = st[119-32*c -: 8];
      a2 = st[111-32*c -: 8];
      a3 = st[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [127:0] keyed;
  logic         accept;

  assign keyed = inv_shift_sub(data_q) ^ rk_data;

`ifdef AES_INV_ABORT_EN
  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready & ~abort));
`else
  assign in_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
`endif
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == ROUND) | (state_q == LAST);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // Idle/done present key NR so the first key is ready the moment a block is accepted.
  always_comb begin
    rk_idx = NR4;
    case (state_q)
      ROUND:   rk_idx = r_q;
      LAST:    rk_idx = 4'd0;
      default: rk_idx = NR4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = in_data ^ rk_data;
          r_d     = NR4 - 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = inv_mix_columns(keyed);
        r_d    = (r_q == 4'd0) ? 4'd0 : r_q - 4'd1;
        if (r_q == 4'd1) state_d = LAST;
      end
      LAST: begin
        out_data_d  = keyed;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (accept) begin
            data_d  = in_data ^ rk_data;
            r_d     = NR4 - 4'd1;
            state_d = ROUND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_INV_ABORT_EN
    if (abort && (state_q == ROUND || state_q == LAST)) begin
      state_d     = IDLE;
      r_d         = 4'd0;
      data_d      = '0;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r_q         <= 4'd0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter using FIPS-197 vectors and a key-store model.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;
`ifdef AES_INV_ABORT_EN
  logic         abort;
`endif

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_INV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int cur_key  = 0;
  int pend_key = 0;
  bit pend_push = 0;
  bit ov_prev   = 0;
  logic [127:0] pend_exp;
  logic [127:0] rk_tab [2][11];
  logic [127:0] exp_q [$];
  int acc_q [$];
  int rise_q [$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 0; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv, p;
    inv = 8'h00;
    for (int i = 0; i < 256; i++) begin
      p = 8'(i);
      if (gmul(x, p) == 8'h01) inv = p;
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] o;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rcon, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) o[1407-32*i -: 32] = w[i];
    return o;
  endfunction

  // Key store: during an accept it serves the key of the block being presented.
  always_comb begin
    rk_data = '0;
    if (rk_idx <= 4'd10) begin
      if (in_valid && in_ready) rk_data = rk_tab[pend_key][rk_idx];
      else                      rk_data = rk_tab[cur_key][rk_idx];
    end
  end

  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      cur_key <= pend_key;
      n_acc   <= n_acc + 1;
      if (pend_push) begin
        exp_q.push_back(pend_exp);
        acc_q.push_back(cyc);
      end
    end
    cyc <= cyc + 1;
  end

  // Monitor: latency on every out_valid rise, plaintext on every transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev <= 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        rise_q.push_back(cyc);
        if (acc_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_out_valid: got out_valid=1 required no output at cycle %0d", cyc);
        end else begin
          chk("latency", 128'(cyc - acc_q.pop_front()), 128'd11);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got %h required no transfer", out_data);
        end else begin
          chk("plaintext", out_data, exp_q.pop_front());
        end
      end
      ov_prev <= out_valid;
    end
  end

  task automatic send(input logic [127:0] d, input int key, input logic [127:0] exp, input bit push);
    int t;
    @(posedge clk); #1;
    in_data = d; pend_key = key; pend_exp = exp; pend_push = push; in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 128'(in_ready), 128'd1);
      in_valid = 1'b0; pend_push = 0;
    end else begin
      chk("rk_idx_at_accept", 128'(rk_idx), 128'd10);
      @(posedge clk); #1;
      in_valid = 1'b0; pend_push = 0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    logic [1407:0] ex;
    int acc0, cnt;
    ex = expand(C1_KEY);
    for (int i = 0; i < 11; i++) rk_tab[0][i] = ex[1407-128*i -: 128];
    ex = expand(B_KEY);
    for (int i = 0; i < 11; i++) rk_tab[1][i] = ex[1407-128*i -: 128];

    rst_n = 0; in_valid = 0; in_data = '0; out_ready = 1;
`ifdef AES_INV_ABORT_EN
    abort = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd10);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // C.1 with round-key index sequence
    send(C1_CT, 0, C1_PT, 1);
    for (int k = 9; k >= 0; k--) begin
      @(negedge clk);
      chk("rk_idx_seq", 128'(rk_idx), 128'(k));
    end
    drain();

    // Appendix B then C.1 back to back
    rise_q.delete();
    send(B_CT, 1, B_PT, 1);
    send(C1_CT, 0, C1_PT, 1);
    drain();
    chk("b2b_rises", 128'(rise_q.size()), 128'd2);
    if (rise_q.size() == 2) chk("b2b_gap", 128'(rise_q[1] - rise_q[0]), 128'd11);

    // Backpressure
    out_ready = 0;
    acc0 = n_acc;
    send(C1_CT, 0, C1_PT, 1);
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = (k % 2 == 0);
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      chk("bp_out_data", out_data, C1_PT);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #1 in_valid = 0; out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_single_transfer", 128'(out_valid), 128'd0);
    chk("bp_accepts", 128'(n_acc - acc0), 128'd1);
    drain();

    // Reset in the middle of a block
    send(C1_CT, 0, C1_PT, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("mid_rst_no_output", 128'(cnt), 128'd0);
    send(C1_CT, 0, C1_PT, 1);
    drain();

    // in_valid held with junk while busy
    acc0 = n_acc;
    send(C1_CT, 0, C1_PT, 1);
    in_valid = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
    end
    in_valid = 0;
    drain();
    chk("busy_accepts", 128'(n_acc - acc0), 128'd1);

`ifdef AES_INV_ABORT_EN
    send(C1_CT, 0, C1_PT, 0);
    repeat (3) @(posedge clk);
    #1 abort = 1;
    @(negedge clk);
    chk("abort_busy_before", 128'(busy), 128'd1);
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("abort_no_output", 128'(cnt), 128'd0);
    send(C1_CT, 0, C1_PT, 1);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
